// File: rtl/uart_sample_rx.sv
// 8N1 UART receiver that packs four bytes, LSB byte first, into one 32-bit sample
// and hands it to a consumer through a single-entry valid/ready holding register.
module uart_sample_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [31:0] sample,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        frame_err,
  output logic        overrun,
  output logic [1:0]  state_dbg
);

  localparam int HALF_BIT  = CLKS_PER_BIT / 2;
  localparam int BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W      = $clog2(TO_CYCLES);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

  state_t              state_q, state_d;
  logic                rx_meta_q, rx_s_q;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic [1:0]          idx_q, idx_d;
  logic [31:0]         word_q, word_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic                armed_q, armed_d;
  logic [31:0]         sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                fe_q, fe_d;
  logic                ov_q, ov_d;
  logic                byte_ok;

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign frame_err    = fe_q;
  assign overrun      = ov_q;
  assign state_dbg    = state_q;

  // Synchronizer presets to idle-high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      idx_q    <= '0;
      word_q   <= '0;
      to_q     <= '0;
      armed_q  <= 1'b1;
      sample_q <= '0;
      valid_q  <= 1'b0;
      fe_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      to_q     <= to_d;
      armed_q  <= armed_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      fe_q     <= fe_d;
      ov_q     <= ov_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    word_d   = word_q;
    to_d     = to_q;
    armed_d  = armed_q | rx_s_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    fe_d     = 1'b0;
    ov_d     = 1'b0;
    byte_ok  = 1'b0;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (idx_q != 2'd0) begin
          if (to_q == TO_W'(TO_CYCLES - 1)) begin
            idx_d = 2'd0;
            to_d  = '0;
          end else begin
            to_d = to_q + 1'b1;
          end
        end else begin
          to_d = '0;
        end
        // armed_q blocks a stuck-low line after a framing error from re-triggering.
        if (armed_q && !rx_s_q) begin
          state_d = START;
          to_d    = '0;
        end
      end
      START: begin
        if (baud_q == BAUD_W'(HALF_BIT - 1)) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (baud_q == BAUD_W'(CLKS_PER_BIT - 1)) begin
          baud_d  = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (baud_q == BAUD_W'(CLKS_PER_BIT - 1)) begin
          baud_d  = '0;
          state_d = IDLE;
          if (rx_s_q) begin
            byte_ok = 1'b1;
          end else begin
            fe_d    = 1'b1;
            idx_d   = 2'd0;
            armed_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake: a word transfers on any edge where sample_valid && sample_ready;
    // sample_valid never drops without that, and sample is frozen while valid.
    if (valid_q && sample_ready) valid_d = 1'b0;

    if (byte_ok) begin
      if (idx_q == 2'd3) begin
        idx_d = 2'd0;
        if (!valid_q || sample_ready) begin
          sample_d = {shift_q, word_q[23:0]};
          valid_d  = 1'b1;
        end else begin
          ov_d = 1'b1;
        end
      end else begin
        word_d[8*idx_q +: 8] = shift_q;
        idx_d                = idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_sample_rx.sv
// Directed bench for uart_sample_rx: serial bytes in, packed words checked against
// hand-computed values plus frame_err/overrun pulse counts.
module tb_uart_sample_rx;

  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        sample_ready = 1'b1;
  logic [31:0] sample;
  logic        sample_valid;
  logic        frame_err;
  logic        overrun;
  logic [1:0]  state_dbg;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int rd_idx   = 0;
  int fe_base, ov_base;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  uart_sample_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(20)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      if (sample_valid && sample_ready) got_q.push_back(sample);
      if (frame_err === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
  endtask

  task automatic check_words(input string tag);
    chk({tag, "_count"}, 32'(got_q.size() - rd_idx), 32'(exp_q.size()));
    while (exp_q.size() != 0) begin
      logic [31:0] e, g;
      e = exp_q.pop_front();
      g = (rd_idx < got_q.size()) ? got_q[rd_idx] : 32'hxxxx_xxxx;
      rd_idx++;
      chk({tag, "_word"}, g, e);
    end
    rd_idx = got_q.size();
  endtask

  task automatic snap();
    fe_base = fe_cnt;
    ov_base = ov_cnt;
  endtask

  initial begin
    // reset state
    tick(3);
    chk("rst_sample", sample, 32'h0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_fe", 32'(frame_err), 32'd0);
    chk("rst_ov", 32'(overrun), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    tick(4);

    // 1: back-to-back bytes, consumer always ready
    snap();
    send_word(32'h1234_5678);
    tick(4);
    exp_q.push_back(32'h1234_5678);
    check_words("t1");
    chk("t1_valid_low", 32'(sample_valid), 32'd0);
    chk("t1_sample_kept", sample, 32'h1234_5678);
    chk("t1_no_ov", 32'(ov_cnt - ov_base), 32'd0);

    // 2: holding register full -> second word overruns
    snap();
    sample_ready = 1'b0;
    send_word(32'hDEAD_BEEF);
    tick(1);
    chk("t2_valid_first", 32'(sample_valid), 32'd1);
    chk("t2_sample_first", sample, 32'hDEAD_BEEF);
    send_word(32'h0000_0001);
    tick(4);
    chk("t2_ov_pulses", 32'(ov_cnt - ov_base), 32'd1);
    chk("t2_sample_held", sample, 32'hDEAD_BEEF);
    chk("t2_valid_held", 32'(sample_valid), 32'd1);
    sample_ready = 1'b1;
    tick(1);
    chk("t2_valid_drop", 32'(sample_valid), 32'd0);
    chk("t2_sample_after", sample, 32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
    check_words("t2");

    // 3: framing error resyncs packing
    snap();
    send_byte(8'hAA, 1'b0);
    tick(2 * CPB);
    chk("t3_fe_pulses", 32'(fe_cnt - fe_base), 32'd1);
    send_word(32'h0403_0201);
    tick(4);
    exp_q.push_back(32'h0403_0201);
    check_words("t3");

    // 4: idle gap longer than the timeout discards the partial word
    snap();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    tick(200);
    send_word(32'h0403_0201);
    tick(4);
    exp_q.push_back(32'h0403_0201);
    check_words("t4");
    chk("t4_no_fe", 32'(fe_cnt - fe_base), 32'd0);

    // 5: short low glitch is rejected and leaves byte alignment alone
    snap();
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(20);
    chk("t5_state", 32'(state_dbg), 32'd0);
    chk("t5_no_fe", 32'(fe_cnt - fe_base), 32'd0);
    check_words("t5_none");
    send_word(32'h8877_6655);
    tick(4);
    exp_q.push_back(32'h8877_6655);
    check_words("t5");

    // 6: reset in the middle of byte 2
    snap();
    send_byte(8'h99, 1'b1);
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(3 * CPB);
    chk("t6_in_data", 32'(state_dbg), 32'd2);
    rst = 1'b1;
    tick(2);
    chk("t6_rst_sample", sample, 32'h0);
    chk("t6_rst_valid", 32'(sample_valid), 32'd0);
    chk("t6_rst_fe", 32'(frame_err), 32'd0);
    chk("t6_rst_ov", 32'(overrun), 32'd0);
    chk("t6_rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    tick(20);
    send_word(32'hD0C0_B0A0);
    tick(4);
    exp_q.push_back(32'hD0C0_B0A0);
    check_words("t6");
    chk("t6_no_fe", 32'(fe_cnt - fe_base), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
